// File: rtl/fetch_unit_if.sv
// Fetch bus bundle: instruction-memory read port, decode handshake,
// execute redirect and the retired-instruction counter.
interface fetch_unit_if;
    logic [31:0] mem_addr;
    logic        mem_rstrb;
    logic [31:0] mem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr_count;

    // fetch unit side
    modport master (
        output mem_addr, mem_rstrb, instr, instr_pc, instr_valid, instr_count,
        input  mem_rdata, instr_ready, redirect, redirect_pc
    );

    // memory / decode / execute side
    modport slave (
        input  mem_addr, mem_rstrb, instr, instr_pc, instr_valid, instr_count,
        output mem_rdata, instr_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, strobes word reads into a registered-read
// memory, holds each fetched word for decode until it is accepted, and
// restarts from a new PC on redirect.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);
    localparam logic [31:0] ALIGN   = 32'hFFFF_FFFC;
    localparam logic [31:0] PC_INIT = RESET_PC & ALIGN;

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_VALID} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] instr_q;
    logic [31:0] instr_pc_q;
    logic        valid_q;
    logic [31:0] count_q;
    logic        handshake;

    assign handshake       = valid_q && bus.instr_ready;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = valid_q;
    assign bus.instr_count = count_q;

    // Read strobe: fresh request in REQ, or back-to-back fetch of pc+4 on a
    // handshake; a redirect or reset suppresses it.
    always_comb begin
        bus.mem_addr  = (state == S_VALID) ? pc + 32'd4 : pc;
        bus.mem_rstrb = 1'b0;
        if (!reset && !bus.redirect)
            bus.mem_rstrb = (state == S_REQ) || (state == S_VALID && bus.instr_ready);
    end

    // Fetch FSM; handshake counting is independent of redirect so a
    // coincident accept still retires.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_REQ;
            pc         <= PC_INIT;
            instr_q    <= 32'd0;
            instr_pc_q <= PC_INIT;
            valid_q    <= 1'b0;
            count_q    <= 32'd0;
        end else begin
            if (handshake)
                count_q <= count_q + 32'd1;
            if (bus.redirect) begin
                // drops any outstanding read: WAIT data never captured
                pc      <= bus.redirect_pc & ALIGN;
                valid_q <= 1'b0;
                state   <= S_REQ;
            end else begin
                case (state)
                    S_REQ: state <= S_WAIT;
                    S_WAIT: begin
                        instr_q    <= bus.mem_rdata;
                        instr_pc_q <= pc;
                        valid_q    <= 1'b1;
                        state      <= S_VALID;
                    end
                    S_VALID: begin
                        if (bus.instr_ready) begin
                            pc      <= pc + 32'd4;
                            valid_q <= 1'b0;
                            state   <= S_WAIT;
                        end
                    end
                    default: state <= S_REQ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a random phase, all checked
// cycle by cycle against a transaction-level timing model.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_unit_if ifm ();
    fetch_unit_if if1 ();

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut0 (.clk(clk), .reset(reset), .bus(ifm));
    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut1 (.clk(clk), .reset(reset), .bus(if1));

    assign if1.instr_ready = ifm.instr_ready;
    assign if1.redirect    = 1'b0;
    assign if1.redirect_pc = 32'd0;

    // 256-word memories, word i = 32'h1000_0000 + i, registered read
    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'h1000_0000 + {24'd0, a[9:2]};
    endfunction
    always @(posedge clk) if (ifm.mem_rstrb) ifm.mem_rdata <= word(ifm.mem_addr);
    always @(posedge clk) if (if1.mem_rstrb) if1.mem_rdata <= word(if1.mem_addr);

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Reference model: events scheduled by cycle number
    int          cyc = 0;
    int          strobe_due = -1;   // cycle a fresh request must be strobed
    int          valid_due = -1;    // cycle whose edge delivers the pending word
    logic [31:0] fetch_pc = 32'd0;
    logic [31:0] pend = 32'd0;
    logic        m_valid = 1'b0;
    logic [31:0] m_pc = 32'd0;
    logic [31:0] m_instr = 32'd0;
    logic [31:0] m_count = 32'd0;
    logic        track1 = 1'b0;
    logic [31:0] d1_addrs[$];

    task automatic step(input logic rst_i, input logic rdy, input logic rd, input logic [31:0] rpc);
        logic hs, es;
        logic [31:0] ea;
        reset           = rst_i;
        ifm.instr_ready = rdy;
        ifm.redirect    = rd;
        ifm.redirect_pc = rpc;
        #1;
        hs = !rst_i && m_valid && rdy;
        es = 1'b0;
        ea = 32'd0;
        if (!rst_i && !rd) begin
            if (strobe_due == cyc) begin es = 1'b1; ea = fetch_pc; end
            else if (hs)           begin es = 1'b1; ea = m_pc + 32'd4; end
        end
        chk("mem_rstrb", {31'd0, ifm.mem_rstrb}, {31'd0, es});
        if (es) chk("mem_addr", ifm.mem_addr, ea);
        if (track1 && if1.mem_rstrb) d1_addrs.push_back(if1.mem_addr);
        @(posedge clk);
        #1;
        if (rst_i) begin
            m_valid = 1'b0; m_count = 32'd0; valid_due = -1;
            strobe_due = cyc + 1; fetch_pc = 32'd0;
        end else begin
            if (hs) m_count = m_count + 32'd1;
            if (rd) begin
                m_valid = 1'b0; valid_due = -1;
                strobe_due = cyc + 1; fetch_pc = rpc & 32'hFFFF_FFFC;
            end else begin
                if (valid_due == cyc) begin
                    m_valid = 1'b1; m_pc = pend; m_instr = word(pend); valid_due = -1;
                end
                if (es) begin
                    if (hs) m_valid = 1'b0;
                    valid_due = cyc + 1;
                    pend = ea;
                end
            end
        end
        cyc++;
        chk("instr_valid", {31'd0, ifm.instr_valid}, {31'd0, m_valid});
        if (m_valid) begin
            chk("instr", ifm.instr, m_instr);
            chk("instr_pc", ifm.instr_pc, m_pc);
        end
        chk("instr_count", ifm.instr_count, m_count);
    endtask

    initial begin
        logic [31:0] cnt0;
        reset           = 1'b1;
        ifm.instr_ready = 1'b1;
        ifm.redirect    = 1'b0;
        ifm.redirect_pc = 32'd0;
        @(posedge clk);
        #1;

        // reset state
        step(1'b1, 1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        chk("rst_instr", ifm.instr, 32'd0);
        chk("rst_instr_pc", ifm.instr_pc, 32'd0);
        chk("rst_d1_instr_pc", if1.instr_pc, 32'hFFFF_FFFC);

        // streaming with ready high for 20 cycles
        track1 = 1'b1;
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 32'd0);
        track1 = 1'b0;
        chk("stream_count", ifm.instr_count, 32'd9);
        chk("stream_valid", {31'd0, ifm.instr_valid}, 32'd1);
        chk("d1_nstrobe", d1_addrs.size(), 32'd10);
        if (d1_addrs.size() >= 2) begin
            chk("d1_first_addr", d1_addrs[0], 32'hFFFF_FFFC);
            chk("d1_wrap_addr", d1_addrs[1], 32'h0000_0000);
        end
        chk("d1_instr_pc", if1.instr_pc, 32'h0000_0020);
        chk("d1_instr", if1.instr, 32'h1000_0008);
        chk("d1_count", if1.instr_count, 32'd9);

        // decode stall for 5 cycles, then accept
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 32'd0);
        chk("stall_count", ifm.instr_count, 32'd9);
        step(1'b0, 1'b1, 1'b0, 32'd0);

        // redirect while the next read is outstanding
        step(1'b0, 1'b0, 1'b1, 32'h0000_0043);
        for (int i = 0; i < 10 && !m_valid; i++) step(1'b0, 1'b0, 1'b0, 32'd0);
        chk("redir_wait_pc", ifm.instr_pc, 32'h0000_0040);
        chk("redir_wait_instr", ifm.instr, 32'h1000_0010);

        // redirect coincident with a handshake
        cnt0 = ifm.instr_count;
        step(1'b0, 1'b1, 1'b1, 32'h0000_0020);
        chk("redir_hs_count", ifm.instr_count, cnt0 + 32'd1);
        for (int i = 0; i < 10 && !m_valid; i++) step(1'b0, 1'b0, 1'b0, 32'd0);
        chk("redir_hs_pc", ifm.instr_pc, 32'h0000_0020);
        chk("redir_hs_instr", ifm.instr, 32'h1000_0008);

        // random traffic
        for (int i = 0; i < 400; i++)
            step(1'b0, ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0), $urandom);

        // reset mid-run dominates redirect and handshake
        step(1'b1, 1'b1, 1'b1, $urandom);
        chk("midrst_valid", {31'd0, ifm.instr_valid}, 32'd0);
        chk("midrst_count", ifm.instr_count, 32'd0);
        for (int i = 0; i < 12; i++) step(1'b0, ($urandom_range(0, 1) == 1), 1'b0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
